natalius_wb_master: RTL and testbench

- Wishbone classic single-transfer initiator; drives the wbs_* slave port of natalius_soc from a simple command/response interface.
- Used for the on-chip loader path and for the verification harness that preloads and reads back SoC memory.
- Issues one transfer per command with registered outputs and a bounded wait for acknowledge.

---
 rtl/natalius_wb_pkg.sv | 21 ++
 rtl/natalius_wb_master_if.sv | 54 +++++
 rtl/natalius_wb_timer.sv | 31 +++
 rtl/natalius_wb_master.sv | 136 +++++++++++++
 tb/tb_natalius_wb_master.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/natalius_wb_pkg.sv
// Shared types and defaults for the natalius Wishbone initiator.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package natalius_wb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int AW_DEF      = 32;
    localparam int DW_DEF      = 32;
    localparam int TIMEOUT_DEF = 255;

    // One byte-select bit per data byte.
    function automatic int sel_width(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/natalius_wb_master_if.sv
// Command/response and Wishbone classic signal bundle for natalius_wb_master.
// Latency: n/a (wires only).
// Backpressure: cmd_valid/cmd_ready and rsp_valid/rsp_ready handshakes.
// Modports: master = initiator side (the design), slave = command source plus
// Wishbone target (loader, harness or testbench).
interface natalius_wb_master_if
    import natalius_wb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
);
    localparam int SW = sel_width(DW);

    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_we;
    logic [SW-1:0] cmd_sel;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;

    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;

    logic          wbm_cyc_o;
    logic          wbm_stb_o;
    logic          wbm_we_o;
    logic [SW-1:0] wbm_sel_o;
    logic [AW-1:0] wbm_adr_o;
    logic [DW-1:0] wbm_dat_o;
    logic [DW-1:0] wbm_dat_i;
    logic          wbm_ack_i;
    logic          wbm_err_i;

    modport master (
        input  cmd_valid, cmd_we, cmd_sel, cmd_addr, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        input  wbm_dat_i, wbm_ack_i, wbm_err_i
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_sel, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        output wbm_dat_i, wbm_ack_i, wbm_err_i
    );

endinterface

// File: rtl/natalius_wb_timer.sv
// Acknowledge-wait counter: clear/enable up-counter with terminal count at MAX-1.
// Latency: tc is combinational from the count register; count updates 1 cycle after en.
// Backpressure: none; the owner stops asserting en once tc is acted on.
// Ports: clk, rst (async active-high), clr, en, tc.
module natalius_wb_timer #(
    parameter int MAX = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int TW = $clog2(MAX + 1);

    logic [TW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + TW'(1);
        end
    end

    // Fires on the MAX-th cycle of waiting, so the bus is held exactly MAX cycles.
    assign tc = (count == TW'(MAX - 1));

endmodule

// File: rtl/natalius_wb_master.sv
// Wishbone classic single-transfer initiator driven by a command/response port.
// Latency: 2 cycles command-to-response minimum; one cyc=0 cycle between transfers.
// Backpressure: cmd_ready only in IDLE; response held until rsp_ready.
// Ports: clk, rst (async active-high), bus (natalius_wb_master_if.master).
// Build option: NATALIUS_WB_TIMEOUT_EN adds ack-wait timeout after TIMEOUT cycles.
module natalius_wb_master
    import natalius_wb_pkg::*;
#(
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    natalius_wb_master_if.master bus
);
    localparam int SW = sel_width(DW);

    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("natalius_wb_master: TIMEOUT must be within 1..65535");
    end

    state_t        state, state_nxt;
    logic          accept, term, term_err, rsp_done;
    logic [DW-1:0] term_dat;

    logic          cyc_q, we_q, rsp_vld_q, rsp_err_q;
    logic [SW-1:0] sel_q;
    logic [AW-1:0] adr_q;
    logic [DW-1:0] dat_q, rsp_dat_q;

`ifdef NATALIUS_WB_TIMEOUT_EN
    logic timer_tc;

    natalius_wb_timer #(.MAX(TIMEOUT)) u_timer (
        .clk (clk),
        .rst (rst),
        .clr (accept),
        .en  ((state == BUS) && !term),
        .tc  (timer_tc)
    );
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        term      = 1'b0;
        term_err  = 1'b0;
        term_dat  = '0;
        rsp_done  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    accept    = 1'b1;
                    state_nxt = BUS;
                end
            end
            BUS: begin
                // err wins over a simultaneous ack
                if (bus.wbm_err_i) begin
                    term     = 1'b1;
                    term_err = 1'b1;
                end else if (bus.wbm_ack_i) begin
                    term     = 1'b1;
                    term_dat = we_q ? '0 : bus.wbm_dat_i;
`ifdef NATALIUS_WB_TIMEOUT_EN
                end else if (timer_tc) begin
                    term     = 1'b1;
                    term_err = 1'b1;
`endif
                end
                if (term) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_done  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // All bus and response outputs are registered; the async reset drops
    // cyc/stb and any pending response immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_q     <= 1'b0;
            we_q      <= 1'b0;
            sel_q     <= '0;
            adr_q     <= '0;
            dat_q     <= '0;
            rsp_vld_q <= 1'b0;
            rsp_dat_q <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            cyc_q     <= (state_nxt == BUS);
            rsp_vld_q <= (state_nxt == RESP);
            if (accept) begin
                we_q  <= bus.cmd_we;
                sel_q <= bus.cmd_sel;
                adr_q <= bus.cmd_addr;
                dat_q <= bus.cmd_wdata;
            end
            if (term) begin
                rsp_dat_q <= term_dat;
                rsp_err_q <= term_err;
            end else if (rsp_done) begin
                rsp_dat_q <= '0;
                rsp_err_q <= 1'b0;
            end
        end
    end

    assign bus.cmd_ready = (state == IDLE);
    assign bus.rsp_valid = rsp_vld_q;
    assign bus.rsp_rdata = rsp_dat_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.wbm_cyc_o = cyc_q;
    assign bus.wbm_stb_o = cyc_q;
    assign bus.wbm_we_o  = we_q;
    assign bus.wbm_sel_o = sel_q;
    assign bus.wbm_adr_o = adr_q;
    assign bus.wbm_dat_o = dat_q;

endmodule

// File: tb/tb_natalius_wb_master.sv
// Self-checking bench for natalius_wb_master: directed scenarios plus randomized
// transfers compared against a transfer-level reference model.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_natalius_wb_master;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    natalius_wb_master_if #(.AW(32), .DW(32)) bus ();

    natalius_wb_master #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    // Runs one command through the DUT acting as the Wishbone target.
    // ack_at: 1-based cyc-high cycle on which ack/err are presented (0 = never).
    task automatic run_xfer(
        input  bit we, input logic [3:0] sel, input logic [31:0] adr, input logic [31:0] wdat,
        input  int ack_at, input bit give_ack, input bit give_err, input logic [31:0] rdat,
        input  int rdy_delay, input bit poke_cmd,
        output int cyc_cnt, output int lat, output bit stable, output bit held,
        output logic [31:0] r_dat, output bit r_err, output bit timed_out);
        logic [31:0] d0;
        bit          e0;
        int          k;
        cyc_cnt = 0; lat = 0; stable = 1'b1; held = 1'b1; timed_out = 1'b0;
        r_dat = '0; r_err = 1'b0;
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_we = we; bus.cmd_sel = sel;
        bus.cmd_addr = adr; bus.cmd_wdata = wdat;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        k = 1;
        while (bus.rsp_valid !== 1'b1 && k < 200) begin
            if (bus.wbm_cyc_o === 1'b1) begin
                cyc_cnt++;
                if (bus.wbm_stb_o !== 1'b1 || bus.wbm_we_o !== we || bus.wbm_sel_o !== sel ||
                    bus.wbm_adr_o !== adr || bus.wbm_dat_o !== wdat)
                    stable = 1'b0;
                if (cyc_cnt == ack_at) begin
                    bus.wbm_ack_i = give_ack; bus.wbm_err_i = give_err; bus.wbm_dat_i = rdat;
                end else begin
                    bus.wbm_ack_i = 1'b0; bus.wbm_err_i = 1'b0; bus.wbm_dat_i = $urandom;
                end
            end else begin
                bus.wbm_ack_i = 1'b0; bus.wbm_err_i = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        bus.wbm_ack_i = 1'b0; bus.wbm_err_i = 1'b0;
        if (bus.rsp_valid !== 1'b1) begin
            timed_out = 1'b1;
            return;
        end
        lat = k;
        if (bus.wbm_cyc_o !== 1'b0) stable = 1'b0;
        d0 = bus.rsp_rdata; e0 = bus.rsp_err;
        for (int i = 0; i < rdy_delay; i++) begin
            if (poke_cmd && i == 1) begin
                bus.cmd_valid = 1'b1; bus.cmd_we = 1'b0; bus.cmd_addr = $urandom;
            end else begin
                bus.cmd_valid = 1'b0;
            end
            // stray ack/err while waiting for the response must be ignored
            bus.wbm_ack_i = (i == 2); bus.wbm_err_i = (i == 3);
            @(negedge clk);
            if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== d0 || bus.rsp_err !== e0 ||
                bus.cmd_ready !== 1'b0 || bus.wbm_cyc_o !== 1'b0)
                held = 1'b0;
        end
        bus.cmd_valid = 1'b0; bus.wbm_ack_i = 1'b0; bus.wbm_err_i = 1'b0;
        r_dat = d0; r_err = e0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        bit bad;
        rst = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_we = 1'b0; bus.cmd_sel = '0; bus.cmd_addr = '0;
        bus.cmd_wdata = '0; bus.rsp_ready = 1'b0; bus.wbm_dat_i = '0;
        bus.wbm_ack_i = 1'b0; bus.wbm_err_i = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.cmd_ready, bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, bus.rsp_valid, bus.rsp_err} !== 6'b100000)
            $display("FAIL reset_ctrl: got %b expected 100000",
                     {bus.cmd_ready, bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, bus.rsp_valid, bus.rsp_err});
        else n_pass++;
        n_checks++;
        if ({bus.wbm_sel_o, bus.wbm_adr_o, bus.wbm_dat_o, bus.rsp_rdata} !== 100'd0)
            $display("FAIL reset_data: sel=%h adr=%h dat=%h rdata=%h expected all 0",
                     bus.wbm_sel_o, bus.wbm_adr_o, bus.wbm_dat_o, bus.rsp_rdata);
        else n_pass++;
        // ack/err with no transfer outstanding
        bad = 1'b0;
        bus.wbm_ack_i = 1'b1; bus.wbm_err_i = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0 || bus.wbm_cyc_o !== 1'b0 || bus.cmd_ready !== 1'b1) bad = 1'b1;
        end
        bus.wbm_ack_i = 1'b0; bus.wbm_err_i = 1'b0;
        n_checks++;
        if (bad !== 1'b0) $display("FAIL idle_ack_ignored: got disturbed=%0b expected 0", bad);
        else n_pass++;
    endtask

    task automatic test_write();
        int cc, lat; bit st, hd, er, to; logic [31:0] rd;
        run_xfer(1'b1, 4'hF, 32'h3000_0004, 32'hDEAD_BEEF, 3, 1'b1, 1'b0, 32'h5555_AAAA, 0, 1'b0,
                 cc, lat, st, hd, rd, er, to);
        n_checks++;
        if (to !== 1'b0 || cc !== 3) $display("FAIL write_cyc_len: got %0d (timeout=%0b) expected 3", cc, to);
        else n_pass++;
        n_checks++;
        if (st !== 1'b1) $display("FAIL write_stable: got %0b expected 1", st);
        else n_pass++;
        n_checks++;
        if (er !== 1'b0 || rd !== 32'h0) $display("FAIL write_rsp: got err=%0b rdata=%h expected err=0 rdata=0", er, rd);
        else n_pass++;
        n_checks++;
        if (bus.wbm_adr_o !== 32'h3000_0004 || bus.wbm_dat_o !== 32'hDEAD_BEEF || bus.wbm_we_o !== 1'b1 ||
            bus.cmd_ready !== 1'b1 || bus.wbm_cyc_o !== 1'b0)
            $display("FAIL write_idle_hold: got adr=%h dat=%h we=%0b rdy=%0b cyc=%0b expected 30000004 deadbeef 1 1 0",
                     bus.wbm_adr_o, bus.wbm_dat_o, bus.wbm_we_o, bus.cmd_ready, bus.wbm_cyc_o);
        else n_pass++;
    endtask

    task automatic test_read();
        int cc, lat; bit st, hd, er, to; logic [31:0] rd;
        run_xfer(1'b0, 4'hF, 32'h3000_0008, 32'h0, 1, 1'b1, 1'b0, 32'h0000_1234, 0, 1'b0,
                 cc, lat, st, hd, rd, er, to);
        n_checks++;
        if (to !== 1'b0 || rd !== 32'h0000_1234 || er !== 1'b0)
            $display("FAIL read_rsp: got rdata=%h err=%0b expected 00001234 0", rd, er);
        else n_pass++;
        n_checks++;
        if (lat !== 2) $display("FAIL read_latency: got %0d expected 2", lat);
        else n_pass++;
    endtask

    task automatic test_ack_err_same();
        int cc, lat; bit st, hd, er, to; logic [31:0] rd;
        run_xfer(1'b0, 4'h3, 32'h3000_0010, 32'h0, 2, 1'b1, 1'b1, 32'hCAFE_F00D, 0, 1'b0,
                 cc, lat, st, hd, rd, er, to);
        n_checks++;
        if (to !== 1'b0 || er !== 1'b1 || rd !== 32'h0)
            $display("FAIL ack_err_prio: got err=%0b rdata=%h expected 1 0", er, rd);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int cc, lat; bit st, hd, er, to; logic [31:0] rd;
`ifdef NATALIUS_WB_TIMEOUT_EN
        run_xfer(1'b0, 4'hF, 32'h3000_0020, 32'h0, 0, 1'b0, 1'b0, 32'h0, 0, 1'b0,
                 cc, lat, st, hd, rd, er, to);
        n_checks++;
        if (to !== 1'b0 || cc !== 8) $display("FAIL timeout_len: got %0d expected 8", cc);
        else n_pass++;
        n_checks++;
        if (er !== 1'b1 || rd !== 32'h0) $display("FAIL timeout_rsp: got err=%0b rdata=%h expected 1 0", er, rd);
        else n_pass++;
`else
        run_xfer(1'b0, 4'hF, 32'h3000_0020, 32'h0, 25, 1'b1, 1'b0, 32'h7777_0001, 0, 1'b0,
                 cc, lat, st, hd, rd, er, to);
        n_checks++;
        if (to !== 1'b0 || cc !== 25) $display("FAIL no_timeout_len: got %0d expected 25", cc);
        else n_pass++;
        n_checks++;
        if (er !== 1'b0 || rd !== 32'h7777_0001) $display("FAIL no_timeout_rsp: got err=%0b rdata=%h expected 0 77770001", er, rd);
        else n_pass++;
`endif
        run_xfer(1'b0, 4'hF, 32'h3000_0024, 32'h0, 2, 1'b1, 1'b0, 32'h0BAD_CAFE, 0, 1'b0,
                 cc, lat, st, hd, rd, er, to);
        n_checks++;
        if (to !== 1'b0 || er !== 1'b0 || rd !== 32'h0BAD_CAFE)
            $display("FAIL after_timeout_cmd: got err=%0b rdata=%h expected 0 0badcafe", er, rd);
        else n_pass++;
    endtask

    task automatic test_resp_hold();
        int cc, lat, busy; bit st, hd, er, to; logic [31:0] rd, exp_d;
        exp_d = $urandom;
        run_xfer(1'b0, 4'hF, 32'h3000_0030, 32'h0, 2, 1'b1, 1'b0, exp_d, 5, 1'b1,
                 cc, lat, st, hd, rd, er, to);
        n_checks++;
        if (to !== 1'b0 || hd !== 1'b1) $display("FAIL resp_hold_stable: got %0b expected 1", hd);
        else n_pass++;
        n_checks++;
        if (rd !== exp_d || er !== 1'b0) $display("FAIL resp_hold_data: got %h err=%0b expected %h 0", rd, er, exp_d);
        else n_pass++;
        busy = 0;
        repeat (3) begin
            if (bus.wbm_cyc_o !== 1'b0) busy++;
            @(negedge clk);
        end
        n_checks++;
        if (busy !== 0) $display("FAIL resp_hold_poke_ignored: got %0d busy cycles expected 0", busy);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int pulses, cc, lat; bit st, hd, er, to; logic [31:0] rd;
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_we = 1'b1; bus.cmd_sel = 4'hF;
        bus.cmd_addr = 32'h3000_0040; bus.cmd_wdata = 32'h1111_2222;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.wbm_cyc_o !== 1'b1) $display("FAIL rst_mid_in_bus: got cyc=%0b expected 1", bus.wbm_cyc_o);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (bus.wbm_cyc_o !== 1'b0 || bus.wbm_stb_o !== 1'b0)
            $display("FAIL rst_mid_async: got cyc=%0b stb=%0b expected 0 0", bus.wbm_cyc_o, bus.wbm_stb_o);
        else n_pass++;
        bus.wbm_ack_i = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.wbm_ack_i = 1'b0;
        pulses = 0;
        repeat (4) begin
            if (bus.rsp_valid !== 1'b0) pulses++;
            @(negedge clk);
        end
        n_checks++;
        if (pulses !== 0 || bus.cmd_ready !== 1'b1)
            $display("FAIL rst_mid_after: got rsp_valid cycles=%0d cmd_ready=%0b expected 0 1", pulses, bus.cmd_ready);
        else n_pass++;
        run_xfer(1'b0, 4'h1, 32'h3000_0044, 32'h0, 1, 1'b1, 1'b0, 32'h4242_4242, 1, 1'b0,
                 cc, lat, st, hd, rd, er, to);
        n_checks++;
        if (to !== 1'b0 || rd !== 32'h4242_4242 || er !== 1'b0)
            $display("FAIL rst_mid_recover: got rdata=%h err=%0b expected 42424242 0", rd, er);
        else n_pass++;
    endtask

    // Reference: a transfer ends on the first cycle ack or err is seen; err wins
    // and zeroes the data; writes return 0; the bus is held for exactly ack_at
    // cycles and the response arrives ack_at+1 edges after acceptance.
    task automatic test_random();
        int cc, lat, ack_at, mode, bad_ctrl, bad_rsp;
        bit st, hd, er, to, we, exp_err;
        logic [3:0]  sel;
        logic [31:0] adr, wd, rdat, rd, exp_d;
        bad_ctrl = 0; bad_rsp = 0;
        for (int n = 0; n < 40; n++) begin
            we = 1'(($urandom) & 1); sel = 4'($urandom); adr = $urandom; wd = $urandom;
            rdat = $urandom; ack_at = $urandom_range(1, 6); mode = $urandom_range(0, 2);
            exp_err = (mode != 0);
            exp_d   = (!exp_err && !we) ? rdat : 32'h0;
            run_xfer(we, sel, adr, wd, ack_at, mode != 1, mode != 0, rdat, $urandom_range(0, 3), 1'b0,
                     cc, lat, st, hd, rd, er, to);
            n_checks++;
            if (to !== 1'b0 || cc !== ack_at || lat !== ack_at + 1 || st !== 1'b1 || hd !== 1'b1) begin
                $display("FAIL rand_ctrl[%0d]: got cyc=%0d lat=%0d stable=%0b held=%0b to=%0b expected cyc=%0d lat=%0d 1 1 0",
                         n, cc, lat, st, hd, to, ack_at, ack_at + 1);
                bad_ctrl++;
            end else n_pass++;
            n_checks++;
            if (rd !== exp_d || er !== exp_err) begin
                $display("FAIL rand_rsp[%0d]: got rdata=%h err=%0b expected %h %0b", n, rd, er, exp_d, exp_err);
                bad_rsp++;
            end else n_pass++;
            if (to) break;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, checks passed %0d of %0d", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_ack_err_same();
        test_timeout();
        test_resp_hold();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
